// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/data paths, the shared memory port and the arbiter.
// The arbiter takes the slave modport; the CPU/memory side takes master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic [15:0]       if_grant_cnt;
    logic [15:0]       dm_grant_cnt;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, if_grant_cnt, dm_grant_cnt
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, if_grant_cnt, dm_grant_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data memory; DM has priority,
// a starvation counter forces IF through. Grant counters are built only with ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    mem_port_arbiter_if.slave bus
);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              owner_dm;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [LAT_W-1:0]  lat_cnt;
    logic [STV_W-1:0]  starve_cnt;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              if_ack_r;
    logic              dm_ack_r;
    logic              mem_en_r;

    logic force_if;
    logic dm_win;
    logic if_win;
    logic grant;

    function automatic logic [STV_W-1:0] starve_inc(input logic [STV_W-1:0] v);
        return (v >= STV_MAX) ? STV_MAX : v + 1'b1;
    endfunction

    // Arbitration outcome is only acted on while IDLE.
    assign force_if = bus.if_req && (starve_cnt == STV_MAX);
    assign dm_win   = bus.dm_req && !force_if;
    assign if_win   = bus.if_req && !dm_win;
    assign grant    = (state == IDLE) && (dm_win || if_win);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            owner_dm   <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            if_rdata_r <= '0;
            dm_rdata_r <= '0;
            if_ack_r   <= 1'b0;
            dm_ack_r   <= 1'b0;
            mem_en_r   <= 1'b0;
        end else begin
            if_ack_r <= 1'b0;
            dm_ack_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_req && dm_win)
                        starve_cnt <= starve_inc(starve_cnt);
                    else
                        starve_cnt <= '0;
                    if (dm_win || if_win) begin
                        owner_dm <= dm_win;
                        we_r     <= dm_win && bus.dm_we;
                        addr_r   <= dm_win ? bus.dm_addr : bus.if_addr;
                        wdata_r  <= dm_win ? bus.dm_wdata : '0;
                        lat_cnt  <= LAT_LOAD;
                        mem_en_r <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_cnt == '0) begin
                        // mem_rdata is valid on this last ACCESS cycle; writes keep rdata.
                        if (!we_r) begin
                            if (owner_dm) dm_rdata_r <= bus.mem_rdata;
                            else          if_rdata_r <= bus.mem_rdata;
                        end
                        dm_ack_r <= owner_dm;
                        if_ack_r <= !owner_dm;
                        mem_en_r <= 1'b0;
                        state    <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.if_rdata  = if_rdata_r;
    assign bus.if_ack    = if_ack_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign bus.dm_ack    = dm_ack_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.busy      = (state != IDLE);

`ifdef ARB_STATS_EN
    logic [15:0] if_gcnt;
    logic [15:0] dm_gcnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            if_gcnt <= '0;
            dm_gcnt <= '0;
        end else if (grant) begin
            if (dm_win) dm_gcnt <= sat_inc16(dm_gcnt);
            else        if_gcnt <= sat_inc16(if_gcnt);
        end
    end

    assign bus.if_grant_cnt = if_gcnt;
    assign bus.dm_grant_cnt = dm_gcnt;
`else
    logic unused_grant;
    assign unused_grant     = grant;
    assign bus.if_grant_cnt = 16'd0;
    assign bus.dm_grant_cnt = 16'd0;
`endif
endmodule
